// File: rtl/mips_alu_pkg.sv
// Shared defaults for the pipelined N:1 mux family and a constant-evaluable
// ceil(log2) helper used for select-width defaults and legality checks.
package mips_alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_MUX_N = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mux_n_grp4.sv
// mux_grp4: purely combinational 4:1 word select; one instance per group of
// four inputs in the first pipeline stage of pipe_mux_n.
module mux_grp4
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [1:0]         in_sel,
  output logic [WIDTH-1:0]   out_data
);

  always_comb begin
    out_data = in_data[WIDTH-1:0];
    case (in_sel)
      2'd0: out_data = in_data[0*WIDTH +: WIDTH];
      2'd1: out_data = in_data[1*WIDTH +: WIDTH];
      2'd2: out_data = in_data[2*WIDTH +: WIDTH];
      2'd3: out_data = in_data[3*WIDTH +: WIDTH];
      default: out_data = in_data[0*WIDTH +: WIDTH];
    endcase
  end

endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: two-stage valid/ready N_IN:1 mux (groups of four, then group pick).
// Define PIPE_MUX_ERR_STICKY_EN to make out_err a sticky flag cleared by clr_err.
module pipe_mux_n
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int N_IN  = ALU_MUX_N,
  parameter int SEL_W = clog2(ALU_MUX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_err,
  input  logic                  clr_err
);

  localparam int NG   = N_IN / 4;
  localparam int HI_W = (SEL_W > 2) ? SEL_W - 2 : 1;

  generate
    if ((N_IN % 4) != 0 || N_IN < 4 || N_IN > 64) begin : g_bad_n
      $error("pipe_mux_n: N_IN must be a multiple of 4 in 4..64");
    end
    if (SEL_W != clog2(N_IN)) begin : g_bad_sel_w
      $error("pipe_mux_n: SEL_W must equal ceil(log2(N_IN))");
    end
  endgenerate

  logic [NG-1:0][WIDTH-1:0] grp_win;
  logic [HI_W-1:0]          sel_hi;
  logic                     in_err;

  logic                     v1_reg;
  logic [NG-1:0][WIDTH-1:0] s1_data_reg;
  logic [HI_W-1:0]          s1_hi_reg;
  logic                     s1_err_reg;

  logic                     v2_reg;
  logic [WIDTH-1:0]         s2_data_reg;
  logic                     s2_err_reg;
  logic [WIDTH-1:0]         s2_data_next;

  logic                     ld1;
  logic                     ld2;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      mux_grp4 #(.WIDTH(WIDTH)) u_grp (
        .in_data (in_data[gi*4*WIDTH +: 4*WIDTH]),
        .in_sel  (in_sel[1:0]),
        .out_data(grp_win[gi])
      );
    end
    if (SEL_W > 2) begin : g_hi
      assign sel_hi = in_sel[SEL_W-1:2];
    end else begin : g_no_hi
      assign sel_hi = '0;
    end
  endgenerate

  // Out-of-range selects only exist when N_IN is not a power of two.
  assign in_err = (int'(in_sel) >= N_IN);

  assign ld2      = !v2_reg || out_ready;
  assign ld1      = !v1_reg || ld2;
  assign in_ready = !v1_reg || !v2_reg || out_ready;

  // A missing group yields zero, which is exactly the error-beat payload.
  always_comb begin
    s2_data_next = '0;
    for (int g = 0; g < NG; g++) begin
      if (s1_hi_reg == HI_W'(g)) s2_data_next = s1_data_reg[g];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      s1_data_reg <= '0;
      s1_hi_reg   <= '0;
      s1_err_reg  <= 1'b0;
      v2_reg      <= 1'b0;
      s2_data_reg <= '0;
      s2_err_reg  <= 1'b0;
    end else begin
      if (ld1) begin
        v1_reg <= in_valid;
        if (in_valid) begin
          s1_data_reg <= grp_win;
          s1_hi_reg   <= sel_hi;
          s1_err_reg  <= in_err;
        end
      end
      if (ld2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          s2_data_reg <= s2_data_next;
          s2_err_reg  <= s1_err_reg;
        end
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_data  = s2_data_reg;

`ifdef PIPE_MUX_ERR_STICKY_EN
  logic err_sticky_reg;

  // Set on emission of a tagged beat; set beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if (v2_reg && out_ready && s2_err_reg) begin
      err_sticky_reg <= 1'b1;
    end else if (clr_err) begin
      err_sticky_reg <= 1'b0;
    end
  end

  assign out_err = err_sticky_reg;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign out_err        = v2_reg && s2_err_reg;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed and randomized self-checking bench for pipe_mux_n (default and N_IN=12 builds).
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic [3:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;
  logic         clr_err;

  logic [191:0] in_data12;
  logic [3:0]   in_sel12;
  logic         in_valid12;
  logic         in_ready12;
  logic [15:0]  out_data12;
  logic         out_valid12;
  logic         out_ready12;
  logic         out_err12;
  logic         clr_err12;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipe_mux_n u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .clr_err(clr_err)
  );

  pipe_mux_n #(.WIDTH(16), .N_IN(12), .SEL_W(4)) u_dut12 (
    .clk(clk), .rst(rst), .in_data(in_data12), .in_sel(in_sel12),
    .in_valid(in_valid12), .in_ready(in_ready12), .out_data(out_data12),
    .out_valid(out_valid12), .out_ready(out_ready12), .out_err(out_err12),
    .clr_err(clr_err12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  int acc_n;
  int emit_n;
  int cycles;
  localparam int NBEAT = 1000;

  initial begin
    for (int k = 0; k < 16; k++) in_data[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int k = 0; k < 12; k++) in_data12[k*16 +: 16] = 16'h2000 + 16'(k);
    rst = 1'b1; in_sel = '0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    in_sel12 = '0; in_valid12 = 1'b0; out_ready12 = 1'b1; clr_err12 = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    // Single beat: latency 2.
    in_sel = 4'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 1'b0);
    step();
    chk("lat_c2_valid", out_valid, 1'b1);
    chk("lat_c2_data", out_data, 16'h1005);
    step();
    chk("lat_c3_valid", out_valid, 1'b0);

    // Back-to-back stream.
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      in_sel = 4'(i);
      #1;
      if (i < 16) chk($sformatf("strm_ready%0d", i), in_ready, 1'b1);
      step();
      if (i >= 1 && i <= 16) begin
        chk($sformatf("strm_valid%0d", i - 1), out_valid, 1'b1);
        chk($sformatf("strm_data%0d", i - 1), out_data, 16'h1000 + 16'(i - 1));
      end
    end
    in_valid = 1'b0;
    step();
    chk("strm_drained", out_valid, 1'b0);

    // Backpressure: two accepts then stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 4'd2; #1;
    chk("stall_rdy0", in_ready, 1'b1);
    step();
    in_sel = 4'd3; #1;
    chk("stall_rdy1", in_ready, 1'b1);
    step();
    in_sel = 4'd4; #1;
    chk("stall_rdy2", in_ready, 1'b0);
    step();
    chk("stall_hold_a", out_data, 16'h1002);
    chk("stall_rdy3", in_ready, 1'b0);
    step();
    chk("stall_hold_b", out_data, 16'h1002);
    chk("stall_hold_v", out_valid, 1'b1);
    out_ready = 1'b1; #1;
    chk("rel_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("rel_b1", out_data, 16'h1003);
    step();
    chk("rel_b2", out_data, 16'h1004);
    chk("rel_b2_v", out_valid, 1'b1);
    step();
    chk("rel_empty", out_valid, 1'b0);

    // Reset while both stages are full, with a concurrent load attempt.
    out_ready = 1'b0; in_valid = 1'b1;
    in_sel = 4'd7; step();
    in_sel = 4'd8; step();
    chk("full_valid", out_valid, 1'b1);
    rst = 1'b1; in_sel = 4'd9;
    step();
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 16'h0);
    chk("midrst_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_stale%0d", i), out_valid, 1'b0);
    end

    // N_IN=12: in-range sel 11 then out-of-range sel 13.
    in_sel12 = 4'd11; in_valid12 = 1'b1;
    step();
    in_sel12 = 4'd13;
    step();
    in_valid12 = 1'b0;
    chk("n12_b11_valid", out_valid12, 1'b1);
    chk("n12_b11_data", out_data12, 16'h200B);
    chk("n12_b11_err", out_err12, 1'b0);
    step();
    chk("n12_b13_valid", out_valid12, 1'b1);
    chk("n12_b13_data", out_data12, 16'h0);
`ifdef PIPE_MUX_ERR_STICKY_EN
    chk("n12_b13_err", out_err12, 1'b0);
    step();
    chk("n12_sticky_a", out_err12, 1'b1);
    step(); step();
    chk("n12_sticky_b", out_err12, 1'b1);
    clr_err12 = 1'b1; step(); clr_err12 = 1'b0;
    chk("n12_cleared", out_err12, 1'b0);
`else
    chk("n12_b13_err", out_err12, 1'b1);
    step();
    chk("n12_err_gone", out_err12, 1'b0);
`endif
    // Error beat emitted on the same edge as a clr_err pulse.
    in_sel12 = 4'd13; in_valid12 = 1'b1;
    step();
    in_valid12 = 1'b0;
    step();
    clr_err12 = 1'b1; #1;
`ifdef PIPE_MUX_ERR_STICKY_EN
    chk("n12_coin_pre", out_err12, 1'b0);
    step();
    chk("n12_coin_set", out_err12, 1'b1);
`else
    chk("n12_clr_ignored", out_err12, 1'b1);
    step();
    chk("n12_coin_gone", out_err12, 1'b0);
`endif
    clr_err12 = 1'b0;

    // Randomized valid/ready against a queue model.
    acc_n = 0; emit_n = 0; cycles = 0;
    while (acc_n < NBEAT && cycles < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd_ready%0d", cycles), in_ready, (q.size() < 2) || out_ready);
      if (q.size() == 0) chk($sformatf("rnd_empty%0d", cycles), out_valid, 1'b0);
      if (out_valid && out_ready && q.size() > 0) begin
        chk($sformatf("rnd_beat%0d", emit_n), out_data, q.pop_front());
        emit_n++;
      end
      if (in_valid && in_ready) begin
        q.push_back(16'h1000 + 16'(in_sel));
        acc_n++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (q.size() == 0) chk($sformatf("drain_empty%0d", i), out_valid, 1'b0);
      else if (out_valid) begin
        chk($sformatf("rnd_beat%0d", emit_n), out_data, q.pop_front());
        emit_n++;
      end
      step();
    end
    chk("rnd_accepted", acc_n, NBEAT);
    chk("rnd_emitted", emit_n, acc_n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
